// File: rtl/wishbone_pkg.sv
// wishbone_pkg
//   Shared definitions for the Wishbone master/slave pair: bus widths, the
//   slave FSM state encoding and the value returned for out-of-range reads.
package wishbone_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;
    // Wait-state counter width; covers WAIT_CYCLES up to 15.
    localparam int WAIT_W = 4;

    localparam logic [DATA_W-1:0] OOR_READ_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } wb_state_t;

endpackage

// File: rtl/wishbone_regfile_mem.sv
// wishbone_regfile_mem
//   DEPTH x 64-bit storage with one write port and one registered read port.
//   All words and the read register clear asynchronously on reset.
// Ports:
//   clk_i, rst_i           clock, async active-low reset
//   wr_en_i/idx/data       write port, commits on the rising edge
//   rd_en_i                load the read register this edge
//   rd_hit_i               1 = load the addressed word, 0 = load OOR_READ_DATA
//   rd_idx_i               read word index
//   rd_data_o              registered read data, holds between loads
module wishbone_regfile_mem
    import wishbone_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic              rd_hit_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_idx_i] <= wr_data_i;
            end
            if (rd_en_i) begin
                rd_q <= rd_hit_i ? mem_q[rd_idx_i] : OOR_READ_DATA;
            end
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/wishbone_slave_regfile.sv
// wishbone_slave_regfile
//   Classic single-transfer Wishbone slave in front of a 64-bit register file.
//   Each request is acknowledged exactly once, after WAIT_CYCLES wait states;
//   the slave then holds off until the strobe drops before accepting again.
// Ports:
//   clk_i, rst_i       clock, async active-low reset
//   cyc_i, stb_i       bus cycle / strobe; request = cyc_i & stb_i
//   we_i               1 = write, 0 = read
//   addr_i             byte address (bits [2:0] ignored)
//   data_i             write data
//   ack_o              one-cycle registered acknowledge
//   data_o             registered read data, held until the next read ack
//   xfer_count_o       acknowledged transfers, wraps at 2^16
//   state_o            current FSM state (debug)
//
// Handshake: the master raises cyc_i & stb_i (its "valid") with we/addr/data
// stable; the slave samples those only in IDLE and answers with a single
// ack_o pulse (its "ready"). A transfer completes on that pulse. The master
// may keep the request high afterwards; the slave ignores it until it has
// seen the request low for one cycle.
module wishbone_slave_regfile
    import wishbone_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ack_o,
    output logic [DATA_W-1:0] data_o,
    output logic [15:0]       xfer_count_o,
    output logic [1:0]        state_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One bit wider than the bus so the upper bound cannot wrap.
    localparam logic [ADDR_W:0] ADDR_END =
        {1'b0, ADDR_BASE} + (ADDR_W + 1)'(8 * DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

    wb_state_t         state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              we_q;
    logic              hit_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ack_q;
    logic [15:0]       xfer_cnt_q;

    logic              req;
    logic              live_hit;
    logic [IDX_W-1:0]  live_idx;
    logic              enter_ack;
    logic              op_we;
    logic              op_hit;
    logic [IDX_W-1:0]  op_idx;
    logic [DATA_W-1:0] op_wdata;

    assign req      = cyc_i & stb_i;
    assign live_hit = (addr_i >= ADDR_BASE) && ({1'b0, addr_i} < ADDR_END);
    assign live_idx = IDX_W'((addr_i - ADDR_BASE) >> 3);

    // With no wait states the ACK-entering edge is the IDLE sampling edge,
    // so the operation must come straight from the bus rather than the
    // capture registers, which are only loaded on that same edge.
    always_comb begin
        enter_ack = 1'b0;
        op_we     = we_q;
        op_hit    = hit_q;
        op_idx    = idx_q;
        op_wdata  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                enter_ack = req && (WAIT_CYCLES == 0);
                op_we     = we_i;
                op_hit    = live_hit;
                op_idx    = live_idx;
                op_wdata  = data_i;
            end
            ST_WAIT: enter_ack = req && (wait_cnt_q == WAIT_W'(1));
            default: enter_ack = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            we_q       <= 1'b0;
            hit_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            ack_q      <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            ack_q <= enter_ack;
            if (enter_ack) begin
                xfer_cnt_q <= xfer_cnt_q + 16'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_q       <= we_i;
                        hit_q      <= live_hit;
                        idx_q      <= live_idx;
                        wdata_q    <= data_i;
                        wait_cnt_q <= WAIT_LOAD;
                        state_q    <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACK;
                    end
                end
                ST_WAIT: begin
                    // An abandoned request leaves nothing behind: the
                    // write/read only happens on the ACK-entering edge.
                    if (!req) begin
                        state_q <= ST_IDLE;
                    end else if (wait_cnt_q == WAIT_W'(1)) begin
                        state_q <= ST_ACK;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
                    end
                end
                ST_ACK: state_q <= ST_HOLD;
                ST_HOLD: begin
                    if (!req) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    wishbone_regfile_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (enter_ack & op_we & op_hit),
        .wr_idx_i  (op_idx),
        .wr_data_i (op_wdata),
        .rd_en_i   (enter_ack & ~op_we),
        .rd_hit_i  (op_hit),
        .rd_idx_i  (op_idx),
        .rd_data_o (data_o)
    );

    assign ack_o        = ack_q;
    assign xfer_count_o = xfer_cnt_q;
    assign state_o      = state_q;

endmodule
